// File: rtl/active_frontier_generator_if.sv
// Per-lane write bus, active-vertex stream and iteration-end flags of the frontier generator.
// The generator side is "master"; the writer/consumer side is "slave".
interface active_frontier_generator_if #(
    parameter int V_ID_WIDTH = 20,
    parameter int CORE_NUM   = 32
);
    logic [CORE_NUM*V_ID_WIDTH-1:0] wr_v_id;
    logic [CORE_NUM-1:0]            wr_v_valid;
    logic [CORE_NUM-1:0]            next_full;
    logic [CORE_NUM*V_ID_WIDTH-1:0] active_v_id;
    logic [CORE_NUM-1:0]            active_v_updated;
    logic [CORE_NUM-1:0]            active_v_pull_first_flag;
    logic [CORE_NUM-1:0]            active_v_valid;
    logic [CORE_NUM-1:0]            iteration_end;
    logic [CORE_NUM-1:0]            iteration_end_valid;

    modport master (
        input  wr_v_id, wr_v_valid, next_full,
        output active_v_id, active_v_updated, active_v_pull_first_flag, active_v_valid,
               iteration_end, iteration_end_valid
    );

    modport slave (
        output wr_v_id, wr_v_valid, next_full,
        input  active_v_id, active_v_updated, active_v_pull_first_flag, active_v_valid,
               iteration_end, iteration_end_valid
    );
endinterface

// File: rtl/active_frontier_generator.sv
// Per-lane ping-pong frontier bitmaps; on start each lane scans its `current` slice,
// streams active vertex IDs and raises a sticky iteration_end when its scan completes.
module active_frontier_generator #(
    parameter int V_ID_WIDTH  = 20,
    parameter int CORE_NUM    = 32,
    parameter int LOCAL_V_NUM = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               pull_mode,
    output logic                               busy,
    active_frontier_generator_if.master        bus
);
    localparam int CORE_W  = $clog2(CORE_NUM);
    localparam int LOCAL_W = $clog2(LOCAL_V_NUM);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} lane_state_e;
    typedef logic [LOCAL_V_NUM-1:0] bitmap_t;
    typedef logic [LOCAL_W-1:0]     local_idx_t;
    typedef logic [V_ID_WIDTH-1:0]  v_id_t;

    bitmap_t             cur_q   [CORE_NUM];
    bitmap_t             cur_d   [CORE_NUM];
    bitmap_t             nxt_q   [CORE_NUM];
    bitmap_t             nxt_d   [CORE_NUM];
    lane_state_e         state_q [CORE_NUM];
    lane_state_e         state_d [CORE_NUM];
    local_idx_t          ptr_q   [CORE_NUM];
    local_idx_t          ptr_d   [CORE_NUM];
    logic                pull_q, pull_d;

    // Examine stage: what was read from current[ptr], presented on the following edge.
    logic [CORE_NUM-1:0] ex_valid_q, ex_valid_d, ex_upd_q, ex_upd_d;
    logic [CORE_NUM-1:0] ex_flag_q, ex_flag_d, ex_last_q, ex_last_d;
    local_idx_t          ex_idx_q [CORE_NUM];
    local_idx_t          ex_idx_d [CORE_NUM];

    v_id_t               id_q [CORE_NUM];
    v_id_t               id_d [CORE_NUM];
    logic [CORE_NUM-1:0] upd_q, upd_d, flag_q, flag_d, valid_q, valid_d;
    logic [CORE_NUM-1:0] end_q, end_d, end_valid_q, end_valid_d;

    logic    start_acc;
    v_id_t   wr_id;
    bitmap_t wr_mask;
    logic    cur_bit;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < CORE_NUM; i++) busy |= (state_q[i] == SCAN);
    end

    assign start_acc = start && !busy;

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        state_d     = state_q;
        ptr_d       = ptr_q;
        ex_idx_d    = ex_idx_q;
        ex_upd_d    = ex_upd_q;
        ex_flag_d   = ex_flag_q;
        ex_valid_d  = '0;
        ex_last_d   = '0;
        id_d        = id_q;
        upd_d       = upd_q;
        flag_d      = flag_q;
        valid_d     = ex_valid_q;
        end_valid_d = end_valid_q;
        end_d       = start_acc ? '0 : (end_q | ex_last_q);
        pull_d      = start_acc ? pull_mode : pull_q;
        wr_id       = '0;
        wr_mask     = '0;
        cur_bit     = 1'b0;

        for (int i = 0; i < CORE_NUM; i++) begin
            wr_id   = bus.wr_v_id[i*V_ID_WIDTH +: V_ID_WIDTH];
            wr_mask = '0;
            // A write counts only if it belongs to this lane and fits in the local slice.
            if (bus.wr_v_valid[i] && (wr_id[CORE_W-1:0] == CORE_W'(i)) &&
                ((wr_id >> (CORE_W + LOCAL_W)) == '0))
                wr_mask[wr_id[CORE_W +: LOCAL_W]] = 1'b1;

            if (start_acc) begin
                cur_d[i]       = nxt_q[i] | wr_mask;
                nxt_d[i]       = '0;
                state_d[i]     = SCAN;
                ptr_d[i]       = '0;
                end_valid_d[i] = 1'b1;
            end else begin
                nxt_d[i] = nxt_q[i] | wr_mask;
                if (state_q[i] == SCAN && !bus.next_full[i]) begin
                    cur_bit       = cur_q[i][ptr_q[i]];
                    ex_valid_d[i] = cur_bit | pull_q;
                    ex_upd_d[i]   = cur_bit;
                    ex_flag_d[i]  = pull_q;
                    ex_idx_d[i]   = ptr_q[i];
                    ex_last_d[i]  = (ptr_q[i] == local_idx_t'(LOCAL_V_NUM - 1));
                    ptr_d[i]      = ptr_q[i] + local_idx_t'(1);
                    if (ex_last_d[i]) state_d[i] = DONE;
                end
            end

            if (ex_valid_q[i]) begin
                id_d[i]   = v_id_t'({ex_idx_q[i], CORE_W'(i)});
                upd_d[i]  = ex_upd_q[i];
                flag_d[i] = ex_flag_q[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    // NOTE: the bitmaps are reset too, so a reset always leaves both frontiers empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_q       <= '{default: '0};
            nxt_q       <= '{default: '0};
            state_q     <= '{default: IDLE};
            ptr_q       <= '{default: '0};
            pull_q      <= 1'b0;
            ex_valid_q  <= '0;
            ex_upd_q    <= '0;
            ex_flag_q   <= '0;
            ex_last_q   <= '0;
            ex_idx_q    <= '{default: '0};
            id_q        <= '{default: '0};
            upd_q       <= '0;
            flag_q      <= '0;
            valid_q     <= '0;
            end_q       <= '0;
            end_valid_q <= '0;
        end else begin
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pull_q      <= pull_d;
            ex_valid_q  <= ex_valid_d;
            ex_upd_q    <= ex_upd_d;
            ex_flag_q   <= ex_flag_d;
            ex_last_q   <= ex_last_d;
            ex_idx_q    <= ex_idx_d;
            id_q        <= id_d;
            upd_q       <= upd_d;
            flag_q      <= flag_d;
            valid_q     <= valid_d;
            end_q       <= end_d;
            end_valid_q <= end_valid_d;
        end
    end

    always_comb begin
        bus.active_v_id = '0;
        for (int i = 0; i < CORE_NUM; i++) bus.active_v_id[i*V_ID_WIDTH +: V_ID_WIDTH] = id_q[i];
    end

    assign bus.active_v_updated         = upd_q;
    assign bus.active_v_pull_first_flag = flag_q;
    assign bus.active_v_valid           = valid_q;
    assign bus.iteration_end            = end_q;
    assign bus.iteration_end_valid      = end_valid_q;
endmodule
